// File: rtl/reset_ctrl.sv
// Board reset controller: merges watchdog bites, a debounced button and CSR soft
// resets into a stretched active-low board reset with sticky cause and recovery flag.
module reset_ctrl #(
    parameter logic [4:0] BASE_ADDR    = 5'h0,
    parameter logic [7:0] PULSE_TICKS  = 8'd100,
    parameter logic [3:0] BTN_DEBOUNCE = 4'd8,
    parameter logic [7:0] SOFT_KEY     = 8'hA5,
    parameter logic [7:0] SOFT_KEY_REC = 8'hA7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       pwr_is_off,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic [1:0] wdt_strobe,
    input  logic       force_recovery_mode,
    input  logic       btn_n,
    output logic       rst_out_n,
    output logic       recovery
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    localparam logic [4:0] CTRL_ADDR = BASE_ADDR + 5'd1;
    localparam logic [4:0] CAUSE_RST = 5'b10000;

    state_t     state_reg;
    logic [7:0] pulse_cnt_reg;
    logic       btn_db_reg;
    logic [3:0] db_cnt_reg;
    logic [4:0] cause_reg;
    logic       recovery_reg;
    logic       rst_out_n_reg;

    logic       sel_cause;
    logic       sel_ctrl;
    logic       soft_norm;
    logic       soft_rec;
    logic       soft_trig;
    logic       db_differ;
    logic       db_done;
    logic       btn_press;
    logic [4:0] cause_set;
    logic [4:0] cause_clr;
    logic       any_trig;
    logic       rec_req;

    assign sel_cause = (csr_a == BASE_ADDR);
    assign sel_ctrl  = (csr_a == CTRL_ADDR);
    assign soft_norm = csr_we & sel_ctrl & (csr_di == SOFT_KEY);
    assign soft_rec  = csr_we & sel_ctrl & (csr_di == SOFT_KEY_REC);
    assign soft_trig = soft_norm | soft_rec;

    assign db_differ = (btn_n != btn_db_reg);
    assign db_done   = ({1'b0, db_cnt_reg} + 5'd1) >= {1'b0, BTN_DEBOUNCE};
    // Press edge: the debounced level is about to flip from released to pressed.
    assign btn_press = ce & db_differ & db_done & btn_db_reg;

    // With board power off only the por cause is recorded and no trigger fires.
    assign cause_set = pwr_is_off ? 5'b10000 : {1'b0, soft_trig, btn_press, wdt_strobe};
    assign cause_clr = (csr_we & sel_cause) ? csr_di[4:0] : 5'b0;
    assign any_trig  = ~pwr_is_off & (|cause_set[3:0]);
    assign rec_req   = wdt_strobe[1] | force_recovery_mode | soft_rec;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db_reg <= 1'b1;
            db_cnt_reg <= 4'd0;
        end else if (ce) begin
            if (db_differ) begin
                if (db_done) begin
                    btn_db_reg <= btn_n;
                    db_cnt_reg <= 4'd0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 4'd1;
                end
            end else begin
                db_cnt_reg <= 4'd0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cause
            // A set in the same cycle as a W1C clear wins.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cause_reg[gi] <= CAUSE_RST[gi];
                end else begin
                    cause_reg[gi] <= cause_set[gi] | (cause_reg[gi] & ~cause_clr[gi]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            recovery_reg <= 1'b0;
        end else if (any_trig) begin
            recovery_reg <= rec_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || pwr_is_off || any_trig) begin
            state_reg     <= ST_ASSERT;
            pulse_cnt_reg <= PULSE_TICKS;
            rst_out_n_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    rst_out_n_reg <= 1'b0;
                    if (pulse_cnt_reg == 8'd0) begin
                        state_reg <= ST_WAIT_REL;
                    end else if (ce) begin
                        pulse_cnt_reg <= pulse_cnt_reg - 8'd1;
                        if (pulse_cnt_reg == 8'd1) begin
                            state_reg <= ST_WAIT_REL;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (btn_db_reg) begin
                        state_reg     <= ST_IDLE;
                        rst_out_n_reg <= 1'b1;
                    end else begin
                        rst_out_n_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    rst_out_n_reg <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (sel_cause) begin
            csr_do = {3'b000, cause_reg};
        end else if (sel_ctrl) begin
            csr_do = {7'b0, recovery_reg};
        end
    end

    assign rst_out_n = rst_out_n_reg;
    assign recovery  = recovery_reg;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed scenarios from the test plan plus randomized traffic
// checked every cycle against a rule-level model of the reset controller.
module tb_reset_ctrl;

    localparam logic [4:0] BASE = 5'h06;
    localparam logic [4:0] CTRL = BASE + 5'd1;
    localparam int         P    = 100;
    localparam int         DB   = 8;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       pwr_is_off;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic [1:0] wdt_strobe;
    logic       force_recovery_mode;
    logic       btn_n;
    logic       rst_out_n;
    logic       recovery;

    int n_cmp = 0;
    int n_err = 0;
    int ce_ctr = 0;
    bit ce_rand = 0;
    bit ce_sampled = 0;

    reset_ctrl #(
        .BASE_ADDR    (BASE),
        .PULSE_TICKS  (8'd100),
        .BTN_DEBOUNCE (4'd8),
        .SOFT_KEY     (8'hA5),
        .SOFT_KEY_REC (8'hA7)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ce                  (ce),
        .pwr_is_off          (pwr_is_off),
        .csr_a               (csr_a),
        .csr_di              (csr_di),
        .csr_we              (csr_we),
        .csr_do              (csr_do),
        .wdt_strobe          (wdt_strobe),
        .force_recovery_mode (force_recovery_mode),
        .btn_n               (btn_n),
        .rst_out_n           (rst_out_n),
        .recovery            (recovery)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: board held low while powered off, in reset, or until P ticks after the
    // last trigger have elapsed and the debounced button is released.
    bit       m_low = 1;
    int       m_left = P;
    bit       m_ticks_done = 0;
    bit [4:0] m_cause = 5'h10;
    bit       m_rec = 0;
    bit       m_db = 1;
    int       m_run = 0;
    bit       t_db_old, t_press, t_soft_n, t_soft_r, t_any;
    bit [4:0] t_set, t_clr;

    always @(posedge clk) begin
        if (rst) begin
            m_low = 1; m_left = P; m_ticks_done = 0;
            m_cause = 5'h10; m_rec = 0; m_db = 1; m_run = 0;
        end else begin
            t_db_old = m_db;
            t_press  = 0;
            if (ce) begin
                if (btn_n != m_db) begin
                    m_run = m_run + 1;
                    if (m_run >= DB) begin
                        t_press = m_db;
                        m_db    = btn_n;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            t_soft_n = csr_we && (csr_a == CTRL) && (csr_di == 8'hA5);
            t_soft_r = csr_we && (csr_a == CTRL) && (csr_di == 8'hA7);
            t_set = pwr_is_off ? 5'h10 : {1'b0, t_soft_n | t_soft_r, t_press, wdt_strobe};
            t_clr = (csr_we && csr_a == BASE) ? csr_di[4:0] : 5'h0;
            m_cause = (m_cause & ~t_clr) | t_set;
            t_any = !pwr_is_off && (t_set[3:0] != 0);
            if (t_any) m_rec = wdt_strobe[1] | force_recovery_mode | t_soft_r;
            if (pwr_is_off || t_any) begin
                m_low = 1; m_left = P; m_ticks_done = 0;
            end else if (m_low && !m_ticks_done) begin
                if (ce) begin
                    m_left = m_left - 1;
                    if (m_left <= 0) m_ticks_done = 1;
                end
            end else if (m_low && t_db_old) begin
                m_low = 0;
            end
        end
    end

    function automatic logic [7:0] exp_rd(input logic [4:0] a);
        if (a == BASE) return {3'b000, m_cause};
        if (a == CTRL) return {7'b0, m_rec};
        return 8'h00;
    endfunction

    task step();
        @(negedge clk);
        ce_sampled = ce;
        wdt_strobe = 2'b00;
        csr_we     = 1'b0;
        ce_ctr     = ce_ctr + 1;
        ce = ce_rand ? ($urandom_range(0, 2) == 0) : (ce_ctr % 10 == 0);
    endtask

    task settle();
        for (int i = 0; i < 1200; i++) step();
    endtask

    task test_reset();
        int ticks;
        rst = 1'b1; ce_ctr = 0;
        step(); step();
        n_cmp++;
        if (rst_out_n !== 1'b0) begin n_err++; $display("FAIL reset_rst_out_n: got %b want 0", rst_out_n); end
        n_cmp++;
        if (recovery !== 1'b0) begin n_err++; $display("FAIL reset_recovery: got %b want 0", recovery); end
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do !== 8'h10) begin n_err++; $display("FAIL reset_cause: got %h want 10", csr_do); end
        rst = 1'b0;
        ticks = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (ce_sampled) ticks++;
            n_cmp++;
            if (rst_out_n !== !m_low) begin
                n_err++; $display("FAIL reset_pulse: cycle %0d got %b want %b", i, rst_out_n, !m_low);
            end
            if (rst_out_n === 1'b1) break;
        end
        n_cmp++;
        if (ticks != P || rst_out_n !== 1'b1) begin
            n_err++; $display("FAIL reset_width: got %0d ticks (out=%b) want %0d ticks", ticks, rst_out_n, P);
        end
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do !== 8'h10) begin n_err++; $display("FAIL reset_cause_after: got %h want 10", csr_do); end
        $display("test_reset: pulse of %0d ticks", ticks);
    endtask

    task test_wdt();
        settle();
        wdt_strobe = 2'b10; ce = 1'b0;
        step();
        n_cmp++;
        if (rst_out_n !== 1'b0) begin n_err++; $display("FAIL wdt1_assert: got %b want 0", rst_out_n); end
        n_cmp++;
        if (recovery !== 1'b1) begin n_err++; $display("FAIL wdt1_recovery: got %b want 1", recovery); end
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do[1] !== 1'b1 || csr_do !== exp_rd(BASE)) begin
            n_err++; $display("FAIL wdt1_cause: got %h want %h", csr_do, exp_rd(BASE));
        end
        csr_a = BASE; csr_di = 8'h02; csr_we = 1'b1;
        step();
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do[1] !== 1'b0 || csr_do !== exp_rd(BASE)) begin
            n_err++; $display("FAIL wdt1_w1c: got %h want %h", csr_do, exp_rd(BASE));
        end
        csr_a = CTRL; #1;
        n_cmp++;
        if (csr_do !== 8'h01) begin n_err++; $display("FAIL ctrl_read: got %h want 01", csr_do); end
        settle();
        n_cmp++;
        if (rst_out_n !== 1'b1) begin n_err++; $display("FAIL wdt1_release: got %b want 1", rst_out_n); end
        $display("test_wdt: wdt1 bite, recovery=%b", recovery);
    endtask

    task test_button();
        int k;
        settle();
        btn_n = 1'b0; k = 0;
        while (k < 7) begin step(); if (ce) k++; end
        step(); btn_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        n_cmp++;
        if (rst_out_n !== 1'b1) begin n_err++; $display("FAIL btn_7_samples: got %b want 1", rst_out_n); end
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do[2] !== 1'b0) begin n_err++; $display("FAIL btn_7_cause: got %h want bit2=0", csr_do); end
        btn_n = 1'b0; k = 0;
        while (k < 8) begin step(); if (ce) k++; end
        n_cmp++;
        if (rst_out_n !== 1'b1) begin n_err++; $display("FAIL btn_before_8th: got %b want 1", rst_out_n); end
        step();
        n_cmp++;
        if (rst_out_n !== 1'b0) begin n_err++; $display("FAIL btn_8_samples: got %b want 0", rst_out_n); end
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do[2] !== 1'b1 || csr_do !== exp_rd(BASE)) begin
            n_err++; $display("FAIL btn_cause: got %h want %h", csr_do, exp_rd(BASE));
        end
        for (int i = 0; i < 1500; i++) step();
        n_cmp++;
        if (rst_out_n !== 1'b0) begin n_err++; $display("FAIL btn_held: got %b want 0", rst_out_n); end
        btn_n = 1'b1; k = 0;
        while (k < 8) begin step(); if (ce) k++; end
        n_cmp++;
        if (rst_out_n !== 1'b0) begin n_err++; $display("FAIL btn_7_high: got %b want 0", rst_out_n); end
        step();
        n_cmp++;
        if (rst_out_n !== 1'b0) begin n_err++; $display("FAIL btn_8_high: got %b want 0", rst_out_n); end
        step();
        n_cmp++;
        if (rst_out_n !== 1'b1) begin n_err++; $display("FAIL btn_release: got %b want 1", rst_out_n); end
        $display("test_button: press/hold/release done");
    endtask

    task test_soft();
        int k;
        int ticks;
        settle();
        csr_a = CTRL; csr_di = 8'hA5; csr_we = 1'b1;
        step();
        n_cmp++;
        if (rst_out_n !== 1'b0 || recovery !== 1'b0) begin
            n_err++; $display("FAIL soft_a5: out=%b rec=%b want 0 0", rst_out_n, recovery);
        end
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do[3] !== 1'b1) begin n_err++; $display("FAIL soft_cause: got %h want bit3=1", csr_do); end
        settle();
        csr_a = BASE; csr_di = 8'h08; csr_we = 1'b1;
        step();
        csr_a = CTRL; csr_di = 8'h12; csr_we = 1'b1;
        step(); step();
        csr_a = BASE; #1;
        n_cmp++;
        if (rst_out_n !== 1'b1 || csr_do[3] !== 1'b0) begin
            n_err++; $display("FAIL soft_badkey: out=%b cause=%h want 1, bit3=0", rst_out_n, csr_do);
        end
        wdt_strobe = 2'b01;
        step(); k = 0;
        while (k < 50) begin step(); if (ce_sampled) k++; end
        csr_a = CTRL; csr_di = 8'hA7; csr_we = 1'b1;
        step();
        n_cmp++;
        if (recovery !== 1'b1 || rst_out_n !== 1'b0) begin
            n_err++; $display("FAIL soft_a7: rec=%b out=%b want 1 0", recovery, rst_out_n);
        end
        ticks = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (ce_sampled) ticks++;
            n_cmp++;
            if (rst_out_n !== !m_low) begin
                n_err++; $display("FAIL soft_pulse: cycle %0d got %b want %b", i, rst_out_n, !m_low);
            end
            if (rst_out_n === 1'b1) break;
        end
        n_cmp++;
        if (ticks != P) begin n_err++; $display("FAIL soft_restart: got %0d ticks want %0d", ticks, P); end
        $display("test_soft: restarted pulse of %0d ticks", ticks);
    endtask

    task test_collision();
        wdt_strobe = 2'b01; csr_a = BASE; csr_di = 8'h01; csr_we = 1'b1;
        step();
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do[0] !== 1'b1) begin n_err++; $display("FAIL w1c_collide: got %h want bit0=1", csr_do); end
        csr_a = BASE; csr_di = 8'h01; csr_we = 1'b1;
        step();
        csr_a = BASE; #1;
        n_cmp++;
        if (csr_do[0] !== 1'b0) begin n_err++; $display("FAIL w1c_alone: got %h want bit0=0", csr_do); end
        settle();
        $display("test_collision: set beats clear");
    endtask

    task test_pwr();
        int ticks;
        pwr_is_off = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            csr_a = BASE; #1;
            n_cmp++;
            if (rst_out_n !== 1'b0 || csr_do[4] !== 1'b1 || csr_do !== exp_rd(BASE)) begin
                n_err++; $display("FAIL pwr_off: cycle %0d out=%b cause=%h want 0 %h", i, rst_out_n, csr_do, exp_rd(BASE));
            end
            if (i == 200) wdt_strobe = 2'b01;
            if (i == 300) begin csr_a = BASE; csr_di = 8'h1F; csr_we = 1'b1; end
        end
        pwr_is_off = 1'b0;
        ticks = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (ce_sampled) ticks++;
            if (rst_out_n === 1'b1) break;
        end
        n_cmp++;
        if (ticks != P || rst_out_n !== 1'b1) begin
            n_err++; $display("FAIL pwr_pulse: got %0d ticks (out=%b) want %0d", ticks, rst_out_n, P);
        end
        $display("test_pwr: post-power pulse of %0d ticks", ticks);
    endtask

    task test_random();
        logic [4:0] ra;
        ce_rand = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            step();
            n_cmp++;
            if (rst_out_n !== !m_low || recovery !== m_rec) begin
                n_err++; $display("FAIL rand_out: cycle %0d out=%b rec=%b want %b %b", i, rst_out_n, recovery, !m_low, m_rec);
            end
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : (($urandom_range(0, 1) == 0) ? BASE : CTRL);
            csr_a = ra; #1;
            n_cmp++;
            if (csr_do !== exp_rd(ra)) begin
                n_err++; $display("FAIL rand_csr: cycle %0d addr %h got %h want %h", i, ra, csr_do, exp_rd(ra));
            end
            rst = ($urandom_range(0, 1499) == 0);
            if (pwr_is_off) pwr_is_off = ($urandom_range(0, 49) != 0);
            else            pwr_is_off = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 59) == 0) wdt_strobe = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 99) == 0) force_recovery_mode = ~force_recovery_mode;
            if ($urandom_range(0, 29) == 0) btn_n = ~btn_n;
            if ($urandom_range(0, 299) == 0) btn_n = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                csr_we = 1'b1;
                csr_a  = ($urandom_range(0, 1) == 0) ? BASE : CTRL;
                case ($urandom_range(0, 3))
                    0:       csr_di = 8'hA5;
                    1:       csr_di = 8'hA7;
                    default: csr_di = 8'($urandom_range(0, 255));
                endcase
            end
        end
        ce_rand = 1'b0;
        $display("test_random: 5000 cycles of mixed traffic");
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; pwr_is_off = 1'b0;
        csr_a = 5'h0; csr_di = 8'h0; csr_we = 1'b0;
        wdt_strobe = 2'b00; force_recovery_mode = 1'b0; btn_n = 1'b1;
        test_reset();
        test_wdt();
        test_button();
        test_soft();
        test_collision();
        test_pwr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_ctrl.md
# reset_ctrl

Board reset controller directly downstream of the watchdog. It consumes the watchdog bite strobes and recovery request, the reset button and a CSR soft-reset command. It produces a stretched, active-low board reset and a latched recovery-boot flag, and records the reset cause in a sticky CSR register. It shares the CSR bus and the slow `ce` tick with the watchdog.

## Interface
Parameters:
- BASE_ADDR, 5'h0: CSR window base; the block owns BASE_ADDR+0 and BASE_ADDR+1.
- PULSE_TICKS, 8'd100: reset assertion length in `ce` ticks; must be ≥1.
- BTN_DEBOUNCE, 4'd8: consecutive `ce` samples required to accept a button level change.
- SOFT_KEY, 8'hA5: CSR value that requests a normal soft reset.
- SOFT_KEY_REC, 8'hA7: CSR value that requests a soft reset into recovery.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  synchronous, active-high CPLD power-on reset; never driven from `rst_out_n`.
- ce  in  1  one-cycle slow tick, the same one the watchdog uses.
- pwr_is_off  in  1  board power is off.
- csr_a  in  5  CSR address.
- csr_di  in  8  CSR write data.
- csr_we  in  1  CSR write strobe.
- csr_do  out  8  CSR read data; combinational; 0 outside the owned addresses.
- wdt_strobe  in  2  watchdog bite pulses, one cycle each; either bit is a reset trigger.
- force_recovery_mode  in  1  level; requests a recovery boot.
- btn_n  in  1  reset button, active low, already synchronised to `clk`.
- rst_out_n  out  1  board reset, active low; registered.
- recovery  out  1  recovery-boot flag for the boot-config logic; registered.

## Operation
- Registers:
  - R_CAUSE (+0): bits [4:0] = {por, soft, btn, wdt1, wdt0}. Bits are sticky. Writing 1 to a bit clears it. Reads return 3'b0 in the upper bits.
  - R_CTRL (+1): a write of SOFT_KEY or SOFT_KEY_REC is a soft trigger; any other write value is ignored. Reads return {7'b0, recovery}.
- Triggers: wdt_strobe[0], wdt_strobe[1], the debounced button press edge, and a soft key write.
  - Each trigger sets its cause bit in the same cycle.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Recovery request = wdt_strobe[1] | force_recovery_mode | (soft write of SOFT_KEY_REC).
  - On any trigger, `recovery` is loaded with the recovery request in that cycle.
  - `recovery` is otherwise held; `rst` clears it.
- Debounce:
  - The raw button level is sampled on `ce`.
  - The debounced level flips after BTN_DEBOUNCE consecutive samples that differ from it.
  - Only the press edge (1→0) is a trigger.
- FSM:
  - IDLE: `rst_out_n`=1. Any trigger → ASSERT, and the counter is loaded with PULSE_TICKS.
  - ASSERT: `rst_out_n`=0. The counter decrements on `ce`.
    - A new trigger reloads PULSE_TICKS, which extends the pulse.
    - When the counter reaches 0 → WAIT_REL.
  - WAIT_REL: `rst_out_n`=0.
    - Debounced button released and !pwr_is_off → IDLE.
    - A trigger → ASSERT with a reload.
- pwr_is_off high:
  - The FSM is forced to ASSERT and the counter is held at PULSE_TICKS.
  - The `por` bit is set every cycle; no other cause bit is set.
  - The pulse timing starts when pwr_is_off falls.
- rst:
  - FSM=ASSERT, counter=PULSE_TICKS, R_CAUSE=5'b10000, recovery=0.
  - Debounced button=released (1), debounce counter=0.
  - `rst_out_n`=0 and `recovery`=0 in the cycle after `rst` is sampled.
  - `rst` mid-pulse restarts the full pulse.

## Timing
- A trigger sampled at edge N gives `rst_out_n`=0 and the updated `recovery` after edge N.
- Pulse width from trigger: PULSE_TICKS `ce` ticks, then 1 cycle for the WAIT_REL check. `rst_out_n` rises at the edge after WAIT_REL is entered with its release conditions met.
- Cause bits are visible on `csr_do` the cycle after the trigger.
- The watchdog strobes are single-cycle. They must be captured even when `ce`=0 in that cycle.
- Counter widths: 8-bit pulse counter, 4-bit debounce counter. There is no wrap: the pulse counter saturates at 0.

## Test plan
- After rst, with pwr_is_off=0 and `ce` every 10 cycles → `rst_out_n` low for 100 ticks (~1000 cycles) then high; R_CAUSE=8'h10; recovery=0.
- wdt_strobe=2'b10 for 1 cycle while IDLE → `rst_out_n`=0 next cycle; R_CAUSE bit1 set; recovery=1; W1C write 8'h02 to +0 → R_CAUSE bit1 clear.
- btn_n low for 7 `ce` samples → no reset. Low for 8 samples → reset and btn bit set. Held low past the pulse → `rst_out_n` stays low until 8 high samples.
- Write 8'hA5 to +1 → soft bit set, recovery=0. Write 8'h12 → no effect. Write 8'hA7 mid-pulse → pulse restarts at 100 ticks, recovery=1.
- W1C of bit0 in the same cycle as wdt_strobe[0] → bit0 remains 1.
- pwr_is_off high for 500 cycles → `rst_out_n`=0 throughout, por=1. After it falls → a full 100-tick pulse follows.
